// File: rtl/spi_pkg.sv
// Shared widths, FSM state encoding and response-entry layout for the SPI
// transaction sequencer.
package spi_pkg;

    localparam int NUM_SLAVES = 4;
    localparam int SEL_W      = $clog2(NUM_SLAVES);
    localparam int DATA_W     = 8;

    localparam int CMD_W = SEL_W + DATA_W;

    // Response entry layout: {sel, data, timeout}
    localparam int RSP_W        = SEL_W + DATA_W + 1;
    localparam int RSP_TO_BIT   = 0;
    localparam int RSP_DATA_LSB = 1;
    localparam int RSP_SEL_LSB  = RSP_DATA_LSB + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    function automatic logic [RSP_W-1:0] pack_rsp(
        input logic [SEL_W-1:0]  sel,
        input logic [DATA_W-1:0] data,
        input logic              timeout
    );
        return {sel, data, timeout};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers. A push while full is accepted
// only when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Queues host SPI commands, launches them one at a time on spi_master and
// returns each received byte (or a timeout marker) tagged with its slave.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for a command, a free response slot and done low
//   ST_START | m_start held high for START_CYCLES cycles
//   ST_WAIT  | waiting for done rising edge, bounded by TIMEOUT cycles
//   ST_GAP   | GAP_CYCLES idle cycles before the next launch
module spi_txn_sequencer
    import spi_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int START_CYCLES = 2,
    parameter int GAP_CYCLES   = 2,
    parameter int TIMEOUT      = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [SEL_W-1:0]  rsp_sel,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_timeout,
    output logic              m_start,
    output logic [SEL_W-1:0]  m_slave_sel,
    output logic [DATA_W-1:0] m_mdata,
    input  logic              m_done,
    input  logic [DATA_W-1:0] m_received,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT + START_CYCLES + GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               done_q;
    logic               done_rise;

    logic               cmd_full, cmd_empty, cmd_pop;
    logic [CMD_W-1:0]   cmd_dout;
    logic               rsp_full, rsp_empty, rsp_push, rsp_pop;
    logic [RSP_W-1:0]   rsp_din, rsp_dout;

    assign cmd_ready = !cmd_full;
    assign rsp_valid = !rsp_empty;
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign done_rise = m_done && !done_q;
    assign m_start   = (state == ST_START);
    assign busy      = (state != ST_IDLE);

    assign rsp_sel     = rsp_dout[RSP_SEL_LSB +: SEL_W];
    assign rsp_data    = rsp_dout[RSP_DATA_LSB +: DATA_W];
    assign rsp_timeout = rsp_dout[RSP_TO_BIT];

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid && cmd_ready),
        .din   ({cmd_sel, cmd_data}),
        .pop   (cmd_pop),
        .dout  (cmd_dout),
        .full  (cmd_full),
        .empty (cmd_empty)
    );

    sync_fifo #(.WIDTH(RSP_W), .DEPTH(DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rsp_push),
        .din   (rsp_din),
        .pop   (rsp_pop),
        .dout  (rsp_dout),
        .full  (rsp_full),
        .empty (rsp_empty)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cmd_pop   = 1'b0;
        rsp_push  = 1'b0;
        rsp_din   = '0;
        case (state)
            ST_IDLE: begin
                // Launch only with response space reserved, so WAIT can always push.
                if (!cmd_empty && !rsp_full && !m_done) begin
                    cmd_pop   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (cnt == START_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_WAIT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_WAIT: begin
                if (done_rise || cnt == TO_LAST) begin
                    rsp_push  = 1'b1;
                    rsp_din   = done_rise ? pack_rsp(m_slave_sel, m_received, 1'b0)
                                          : pack_rsp(m_slave_sel, '0, 1'b1);
                    cnt_nxt   = '0;
                    state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            done_q      <= 1'b0;
            m_slave_sel <= '0;
            m_mdata     <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            done_q <= m_done;
            if (cmd_pop) begin
                m_slave_sel <= cmd_dout[DATA_W +: SEL_W];
                m_mdata     <= cmd_dout[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer: the slave side is driven by hand and
// every expected value below is written out explicitly.
module tb_spi_txn_sequencer;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_sel;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_sel;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       m_start;
    logic [1:0] m_slave_sel;
    logic [7:0] m_mdata;
    logic       m_done;
    logic [7:0] m_received;
    logic       busy;

    int checks        = 0;
    int failures      = 0;
    int cyc           = 0;
    int start_cyc     = 0;
    int last_done_cyc = 0;
    int n;
    logic [7:0] rx_tab [4];

    spi_txn_sequencer #(
        .DEPTH(4), .START_CYCLES(2), .GAP_CYCLES(2), .TIMEOUT(1024)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_sel     (cmd_sel),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_sel     (rsp_sel),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .m_start     (m_start),
        .m_slave_sel (m_slave_sel),
        .m_mdata     (m_mdata),
        .m_done      (m_done),
        .m_received  (m_received),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=no_finish required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic [1:0] s, input logic [7:0] d, input logic exp_ready);
        chk("cmd_ready_at_push", {31'd0, cmd_ready}, {31'd0, exp_ready});
        cmd_valid = 1'b1;
        cmd_sel   = s;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start();
        int k;
        k = 0;
        while (m_start !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        chk("start_seen", {31'd0, m_start}, 32'd1);
        start_cyc = cyc;
    endtask

    task automatic wait_start_end(output int len);
        len = 0;
        while (m_start === 1'b1 && len < 20) begin
            tick();
            len++;
        end
    endtask

    task automatic serve(input logic [1:0] s, input logic [7:0] d, input logic [7:0] rx,
                         input bit chk_gap);
        int len;
        wait_start();
        if (chk_gap) chk("gap_done_to_start", start_cyc - last_done_cyc, 32'd3);
        chk("m_slave_sel", {30'd0, m_slave_sel}, {30'd0, s});
        chk("m_mdata", {24'd0, m_mdata}, {24'd0, d});
        wait_start_end(len);
        chk("start_len", len, 32'd2);
        tick();
        tick();
        m_received = rx;
        m_done     = 1'b1;
        tick();
        m_done        = 1'b0;
        last_done_cyc = cyc;
        chk("rsp_valid_after_done", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic pop_rsp(input logic [1:0] s, input logic [7:0] d, input logic to);
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_sel", {30'd0, rsp_sel}, {30'd0, s});
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, d});
        chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, to});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int len;
        rx_tab     = '{8'hB1, 8'hC3, 8'hD4, 8'hE5};
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_sel    = '0;
        cmd_data   = '0;
        rsp_ready  = 1'b0;
        m_done     = 1'b0;
        m_received = '0;
        tick();
        tick();

        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_m_start", {31'd0, m_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_m_slave_sel", {30'd0, m_slave_sel}, 32'd0);
        chk("rst_m_mdata", {24'd0, m_mdata}, 32'd0);
        reset = 1'b0;
        tick();

        // Single transaction with launch latency check
        push_cmd(2'd0, 8'hA2, 1'b1);
        chk("latency_n1", {31'd0, m_start}, 32'd0);
        tick();
        chk("latency_n2", {31'd0, m_start}, 32'd1);
        serve(2'd0, 8'hA2, 8'hB1, 1'b0);
        pop_rsp(2'd0, 8'hB1, 1'b0);
        chk("single_drained", {31'd0, rsp_valid}, 32'd0);

        // Back-to-back: queue four while done holds off the launch
        m_done = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(2'(i), 8'hA2, 1'b1);
        chk("b2b_cmd_full", {31'd0, cmd_ready}, 32'd0);
        chk("b2b_no_launch_done_high", {31'd0, busy}, 32'd0);
        m_done = 1'b0;
        for (int i = 0; i < 4; i++) serve(2'(i), 8'hA2, rx_tab[i], i > 0);
        for (int i = 0; i < 4; i++) pop_rsp(2'(i), rx_tab[i], 1'b0);
        chk("b2b_drained", {31'd0, rsp_valid}, 32'd0);

        // Backpressure: responses not popped
        m_done = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(2'(i), 8'h10 + 8'(i), 1'b1);
        push_cmd(2'd0, 8'hEE, 1'b0);
        m_done = 1'b0;
        for (int i = 0; i < 4; i++) serve(2'(i), 8'h10 + 8'(i), 8'h80 + 8'(i), i > 0);
        push_cmd(2'd1, 8'h20, 1'b1);
        push_cmd(2'd2, 8'h21, 1'b1);
        repeat (20) tick();
        chk("bp_stall_busy", {31'd0, busy}, 32'd0);
        chk("bp_stall_m_start", {31'd0, m_start}, 32'd0);
        chk("bp_rsp_held", {31'd0, rsp_valid}, 32'd1);
        m_done = 1'b1;
        for (int i = 0; i < 4; i++) pop_rsp(2'(i), 8'h80 + 8'(i), 1'b0);
        m_done = 1'b0;
        serve(2'd1, 8'h20, 8'h90, 1'b0);
        serve(2'd2, 8'h21, 8'h91, 1'b1);
        pop_rsp(2'd1, 8'h90, 1'b0);
        pop_rsp(2'd2, 8'h91, 1'b0);
        chk("bp_drained", {31'd0, rsp_valid}, 32'd0);

        // Timeout with no done at all
        push_cmd(2'd2, 8'h55, 1'b1);
        wait_start();
        chk("to_m_slave_sel", {30'd0, m_slave_sel}, 32'd2);
        chk("to_m_mdata", {24'd0, m_mdata}, 32'h55);
        wait_start_end(len);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk("timeout_cycles", n, 32'd1024);
        chk("timeout_busy_in_gap", {31'd0, busy}, 32'd1);
        tick();
        tick();
        chk("timeout_busy_cleared", {31'd0, busy}, 32'd0);
        pop_rsp(2'd2, 8'h00, 1'b1);

        // Done arriving on the final timeout cycle wins
        push_cmd(2'd1, 8'h66, 1'b1);
        wait_start();
        wait_start_end(len);
        repeat (1023) tick();
        m_received = 8'h5A;
        m_done     = 1'b1;
        tick();
        m_done = 1'b0;
        chk("done_wins_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        pop_rsp(2'd1, 8'h5A, 1'b0);

        // Reset mid-WAIT
        push_cmd(2'd3, 8'hC7, 1'b1);
        wait_start();
        wait_start_end(len);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_m_start", {31'd0, m_start}, 32'd0);
        chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_m_mdata", {24'd0, m_mdata}, 32'd0);
        repeat (5) tick();
        chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        push_cmd(2'd1, 8'h3C, 1'b1);
        serve(2'd1, 8'h3C, 8'h77, 1'b0);
        pop_rsp(2'd1, 8'h77, 1'b0);

        // Done stuck high after a transfer
        push_cmd(2'd3, 8'h99, 1'b1);
        wait_start();
        chk("hold_m_mdata", {24'd0, m_mdata}, 32'h99);
        wait_start_end(len);
        tick();
        tick();
        m_received = 8'h42;
        m_done     = 1'b1;
        tick();
        chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        push_cmd(2'd0, 8'h11, 1'b1);
        repeat (20) tick();
        chk("hold_no_launch", {31'd0, busy}, 32'd0);
        pop_rsp(2'd3, 8'h42, 1'b0);
        chk("hold_single_rsp", {31'd0, rsp_valid}, 32'd0);
        m_done = 1'b0;
        serve(2'd0, 8'h11, 8'h22, 1'b0);
        pop_rsp(2'd0, 8'h22, 1'b0);
        chk("final_idle", {31'd0, busy}, 32'd1);
        tick();
        tick();
        chk("final_idle_after_gap", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_txn_sequencer.md
Name: spi_txn_sequencer

Overview:
- Upstream command stage for spi_master.
- Accepts queued (slave_sel, byte) transactions from a host over valid/ready and launches them one at a time by driving the master's start/slave_sel/mdata inputs.
- Waits for the master's done, captures the received byte, and returns it tagged with the slave index through a response valid/ready port.
- Adds a per-transaction timeout so a hung master cannot wedge the host.

Parameters:
- DEPTH, 4, entries in each of the command and response FIFOs (power of 2, ≥2).
- START_CYCLES, 2, number of clk cycles m_start is held high per launch (≥1).
- GAP_CYCLES, 2, idle clk cycles enforced between the end of one transaction and the next launch (≥0).
- TIMEOUT, 1024, clk cycles allowed in WAIT before the transaction is aborted.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host offers a command.
- cmd_ready  out  1  command FIFO not full.
- cmd_sel  in  2  target slave index (0..3).
- cmd_data  in  8  byte to transmit on MOSI.
- rsp_valid  out  1  response FIFO not empty.
- rsp_ready  in  1  host pops a response.
- rsp_sel  out  2  slave index of the head response.
- rsp_data  out  8  byte received from MISO (0x00 on timeout).
- rsp_timeout  out  1  head response was aborted by timeout.
- m_start  out  1  to spi_master start.
- m_slave_sel  out  2  to spi_master slave_sel.
- m_mdata  out  8  to spi_master mdata.
- m_done  in  1  from spi_master done.
- m_received  in  8  from spi_master received byte.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous): both FIFOs emptied; state = IDLE; all counters = 0; done_q = 0.
  - Outputs: cmd_ready = 1, rsp_valid = 0, m_start = 0, m_slave_sel = 0, m_mdata = 0, busy = 0.
  - Reset asserted mid-transaction aborts it with no response generated. m_start drops the cycle after reset is sampled.
- Command FIFO:
  - Push when cmd_valid & cmd_ready.
  - cmd_ready = !full, registered. It does not depend on a same-cycle pop.
- Response FIFO:
  - rsp_valid = !empty. Pop when rsp_valid & rsp_ready.
  - rsp_sel, rsp_data and rsp_timeout come from the head entry and are stable while rsp_valid is high and not popped.
- Done detection: done_q registers m_done; done_rise = m_done & !done_q. A level-high done counts only once.
- State machine:
  - IDLE: leave when the command FIFO is non-empty AND the response FIFO has a free slot AND m_done = 0. Pop the command head and latch sel/data into m_slave_sel/m_mdata; go to START. If the response FIFO is full, stay in IDLE; never launch without guaranteed response space.
  - START: m_start = 1 for exactly START_CYCLES cycles, then go to WAIT. m_slave_sel/m_mdata are held constant from LOAD until the exit from WAIT.
  - WAIT: m_start = 0; the timeout counter increments each cycle.
    - On done_rise: push {sel, m_received, timeout=0}; go to GAP.
    - If the counter reaches TIMEOUT-1 without done_rise: push {sel, 0x00, timeout=1}; go to GAP.
    - If done_rise and the timeout fall in the same cycle, done wins.
  - GAP: count GAP_CYCLES cycles (0 means pass straight through), then go to IDLE.
- Latency:
  - A command pushed at cycle N to an idle block gives m_start high from cycle N+2.
  - The response is visible (rsp_valid) the cycle after done_rise.
- Ordering: responses leave in the same order as commands entered. Exactly one response per accepted command, except commands aborted by reset.
- Simultaneous push and pop:
  - On the response FIFO when full: the pop frees the slot and the push succeeds in the same cycle.
  - On the command FIFO when full: the push is refused (cmd_ready = 0).
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer MSB.

Decomposition:
- Package spi_pkg:
  - SEL_W = 2, DATA_W = 8, NUM_SLAVES = 4.
  - State encoding constants IDLE/START/WAIT/GAP.
  - Response entry width (SEL_W + DATA_W + 1) and field offsets.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; synchronous reset), instantiated twice for the command and response queues.

Test Plan:
- Single transaction: push sel=0 data=0xA2, slave 0 returns 0xB1.
  - m_start is high for 2 cycles and m_mdata = 0xA2.
  - After done, a response {sel=0, data=0xB1, timeout=0} appears.
- Back-to-back: push 4 commands sel=0..3, data 0xA2, with slaves returning 0xB1/0xC3/0xD4/0xE5.
  - The 4 responses come out in order with the matching sel.
  - At least GAP_CYCLES cycles pass between each done and the next m_start.
- Backpressure: hold rsp_ready = 0 and push DEPTH+2 commands.
  - cmd_ready drops when the command FIFO is full.
  - At most DEPTH transactions launch, then the block stalls in IDLE.
  - Releasing rsp_ready drains every response, in order, with no loss.
- Timeout: tie m_done = 0 and push sel=2 data=0x55.
  - After TIMEOUT cycles in WAIT, a response {sel=2, data=0x00, timeout=1} appears and busy returns to 0.
- Reset mid-WAIT: assert reset for 1 cycle during a transaction.
  - The next cycle shows m_start = 0, cmd_ready = 1, rsp_valid = 0, busy = 0.
  - A subsequent command completes normally.
- Done held high: m_done stuck at 1 after a transfer.
  - Only one response is generated.
  - The next launch waits until m_done returns to 0.
